// File: rtl/fp_pkg.sv
// Shared format constants and state encoding for the float <-> linear converters.
package fp_pkg;
  localparam int D_W     = 12;
  localparam int E_W     = 3;
  localparam int F_W     = 4;
  localparam int MAG_MAX = 1920;

  typedef enum logic [1:0] {IDLE, SHIFT, OUT} state_t;
endpackage

// File: rtl/fp_decode.sv
// Expands the 8-bit S/E/F float code into a 12-bit two's-complement value,
// using one left shift per clock, with valid/ready handshakes on both sides.
module fp_decode
  import fp_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           S,
  input  logic [E_W-1:0] E,
  input  logic [F_W-1:0] F,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [D_W-1:0] D
);

  state_t         state, state_nxt;
  logic           s_r, s_nxt;
  logic [E_W-1:0] cnt, cnt_nxt;
  logic [D_W-1:0] mag, mag_nxt;
  logic [D_W-1:0] d_nxt;
  logic           ov_nxt;

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      s_r       <= 1'b0;
      cnt       <= '0;
      mag       <= '0;
      D         <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      s_r       <= s_nxt;
      cnt       <= cnt_nxt;
      mag       <= mag_nxt;
      D         <= d_nxt;
      out_valid <= ov_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    s_nxt     = s_r;
    cnt_nxt   = cnt;
    mag_nxt   = mag;
    d_nxt     = D;
    ov_nxt    = out_valid;
    case (state)
      IDLE: begin
        if (in_valid) begin
          s_nxt     = S;
          cnt_nxt   = E;
          mag_nxt   = {{(D_W-F_W){1'b0}}, F};
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt != '0) begin
          mag_nxt = mag << 1;
          cnt_nxt = cnt - 3'd1;
        end else begin
          // 15*2^7 fits in 12 bits, and negating zero wraps back to zero.
          d_nxt     = s_r ? (~mag + 12'd1) : mag;
          ov_nxt    = 1'b1;
          state_nxt = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          ov_nxt    = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
